// File: rtl/req_encoder_4_2_if.sv
// Request/grant bundle between the raw request sources, the encoder and its consumer.
// master = encoder side, slave = source/consumer side.
interface req_encoder_4_2_if;
    logic [3:0] req;
    logic       en;
    logic       ack;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pending;
    logic       ovf;
    logic       dbg_state;

    modport master (
        input  req, en, ack,
        output code, valid, pending, ovf, dbg_state
    );

    modport slave (
        output req, en, ack,
        input  code, valid, pending, ovf, dbg_state
    );
endinterface

// File: rtl/req_encoder_4_2.sv
// Registered 4-to-2 priority encoder: latches rising edges on req as pending events and
// presents the highest-priority one as a code (line i -> code 3-i) under a valid/ack handshake.
module req_encoder_4_2 (
    input  logic             clk,
    input  logic             reset,
    req_encoder_4_2_if.master bus
);
    // Handshake: code is presented while valid=1 and held stable until the cycle in
    // which ack=1 is sampled; that cycle clears the line and returns to IDLE.
    // ack while valid=0 is ignored.
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] req_q;
    logic [3:0] pending_q, pending_d;
    logic [1:0] code_q, code_d;
    logic       ovf_q, ovf_d;
    logic [3:0] rise_w, set_w, clr_w;
    logic [1:0] prio_code;

    // Line 3 is highest priority, which maps to the lowest code.
    always_comb begin
        prio_code = 2'd0;
        if (pending_q[3])      prio_code = 2'd0;
        else if (pending_q[2]) prio_code = 2'd1;
        else if (pending_q[1]) prio_code = 2'd2;
        else if (pending_q[0]) prio_code = 2'd3;
    end

    always_comb begin
        rise_w = bus.req & ~req_q;
        set_w  = bus.en ? rise_w : 4'b0000;
        clr_w  = 4'b0000;
        if (state_q == PRESENT && bus.ack) clr_w = 4'b1000 >> code_q;
        // Set wins over a same-cycle clear, and such a re-arm is not an overrun.
        pending_d = (pending_q & ~clr_w) | set_w;
        ovf_d     = ovf_q | (|(set_w & pending_q & ~clr_w));

        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (bus.en && (pending_q != 4'b0000)) begin
                    code_d  = prio_code;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 4'b0000;
            pending_q <= 4'b0000;
            code_q    <= 2'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= bus.req;
            pending_q <= pending_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.code      = code_q;
    assign bus.valid     = (state_q == PRESENT);
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_req_encoder_4_2.sv
// Bench for req_encoder_4_2: directed scenarios with literal checks plus random traffic,
// all outputs compared every cycle against an event-level model of the encoder.
module tb_req_encoder_4_2;
    logic clk;
    logic reset;
    req_encoder_4_2_if bus ();

    req_encoder_4_2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model ----------------
    // Tracks lines as individual flags; the presented grant is kept as a line index.
    bit m_prev [4];
    bit m_pend [4];
    bit m_ovf;
    bit m_valid;
    int m_line;
    logic [1:0] exp_q [$];

    function automatic logic [3:0] pend_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_pend[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_line  = 3;
            exp_q.delete();
        end else begin
            bit old_pend [4];
            bit any_old;
            int cleared;
            any_old = 1'b0;
            for (int i = 0; i < 4; i++) begin
                old_pend[i] = m_pend[i];
                any_old     = any_old | m_pend[i];
            end
            cleared = (m_valid && bus.ack) ? m_line : -1;
            for (int i = 0; i < 4; i++) begin
                bit rose;
                rose = bus.req[i] && !m_prev[i] && bus.en;
                if (rose && old_pend[i] && cleared != i) m_ovf = 1'b1;
                if (cleared == i) m_pend[i] = 1'b0;
                if (rose) m_pend[i] = 1'b1;
                m_prev[i] = bus.req[i];
            end
            if (m_valid) begin
                if (bus.ack) m_valid = 1'b0;
            end else if (bus.en && any_old) begin
                for (int i = 0; i < 4; i++) if (old_pend[i]) m_line = i;
                m_valid = 1'b1;
                exp_q.push_back(2'(3 - m_line));
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    bit dut_valid_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", {3'b0, bus.valid}, {3'b0, m_valid});
            chk("pending", bus.pending, pend_vec());
            chk("ovf", {3'b0, bus.ovf}, {3'b0, m_ovf});
            if (m_valid) chk("code", {2'b0, bus.code}, {2'b0, 2'(3 - m_line)});
            if (bus.valid && !dut_valid_prev) begin
                if (exp_q.size() == 0) begin
                    chk("grant_expected", 4'd1, 4'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk("grant_code", {2'b0, bus.code}, {2'b0, e});
                end
            end
        end
        dut_valid_prev = bus.valid;
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic lit(input logic [3:0] pend, input logic vld, input logic [1:0] cd, input logic ov);
        chk("lit_pending", bus.pending, pend);
        chk("lit_valid", {3'b0, bus.valid}, {3'b0, vld});
        if (vld) chk("lit_code", {2'b0, bus.code}, {2'b0, cd});
        chk("lit_ovf", {3'b0, bus.ovf}, {3'b0, ov});
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.en  = 1'b1;
        bus.ack = 1'b0;
        step(2);
        chk_on = 1'b1;
        lit(4'b0000, 1'b0, 2'd0, 1'b0);

        // single event, hold, then ack
        reset = 1'b0; bus.req = 4'b0010;
        step(1); lit(4'b0010, 1'b0, 2'd0, 1'b0);
        bus.req = 4'b0000;
        step(1); lit(4'b0010, 1'b1, 2'd2, 1'b0);
        step(5); lit(4'b0010, 1'b1, 2'd2, 1'b0);
        bus.ack = 1'b1;
        step(1); lit(4'b0000, 1'b0, 2'd0, 1'b0);
        bus.ack = 1'b0;

        // priority order: line 2 before line 0
        bus.req = 4'b0101;
        step(1); lit(4'b0101, 1'b0, 2'd0, 1'b0);
        bus.req = 4'b0000;
        step(1); lit(4'b0101, 1'b1, 2'd1, 1'b0);
        bus.ack = 1'b1;
        step(1); lit(4'b0001, 1'b0, 2'd0, 1'b0);
        bus.ack = 1'b0;
        step(1); lit(4'b0001, 1'b1, 2'd3, 1'b0);
        bus.ack = 1'b1;
        step(1); lit(4'b0000, 1'b0, 2'd0, 1'b0);
        bus.ack = 1'b0;

        // enable gating
        bus.en = 1'b0; bus.req = 4'b1000;
        step(1); bus.req = 4'b0000;
        step(1); lit(4'b0000, 1'b0, 2'd0, 1'b0);
        bus.en = 1'b1; bus.req = 4'b1000;
        step(1); lit(4'b1000, 1'b0, 2'd0, 1'b0);
        bus.en = 1'b0; bus.req = 4'b0000;
        step(3); lit(4'b1000, 1'b0, 2'd0, 1'b0);
        bus.en = 1'b1;
        step(1); lit(4'b1000, 1'b1, 2'd0, 1'b0);
        bus.ack = 1'b1;
        step(1); bus.ack = 1'b0;

        // overrun: re-pulse presented line without ack
        bus.req = 4'b0100;
        step(1); bus.req = 4'b0000;
        step(1); lit(4'b0100, 1'b1, 2'd1, 1'b0);
        bus.req = 4'b0100;
        step(1); lit(4'b0100, 1'b1, 2'd1, 1'b1);
        bus.req = 4'b0000; reset = 1'b1;
        step(1); lit(4'b0000, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        // set wins: re-pulse in the ack cycle
        bus.req = 4'b0100;
        step(1); bus.req = 4'b0000;
        step(1); lit(4'b0100, 1'b1, 2'd1, 1'b0);
        bus.req = 4'b0100; bus.ack = 1'b1;
        step(1); lit(4'b0100, 1'b0, 2'd0, 1'b0);
        bus.req = 4'b0000; bus.ack = 1'b0;
        step(1); lit(4'b0100, 1'b1, 2'd1, 1'b0);
        bus.ack = 1'b1;
        step(1); bus.ack = 1'b0;

        // reset mid-handshake with req[0] held
        bus.req = 4'b0010;
        step(1); bus.req = 4'b0000;
        step(1); bus.req = 4'b1000;
        step(1); lit(4'b1010, 1'b1, 2'd2, 1'b0);
        bus.req = 4'b0001; reset = 1'b1;
        step(1); lit(4'b0000, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;
        step(1); lit(4'b0001, 1'b0, 2'd0, 1'b0);
        step(1); lit(4'b0001, 1'b1, 2'd3, 1'b0);
        bus.req = 4'b0000; bus.ack = 1'b1;
        step(1); bus.ack = 1'b0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.req = 4'($urandom_range(0, 15));
            bus.en  = ($urandom_range(0, 7) != 0);
            bus.ack = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 299) == 0);
            step(1);
        end

        reset = 1'b0; bus.en = 1'b0; bus.ack = 1'b0; bus.req = 4'b0000;
        step(3);
        chk("grants_left", 4'(exp_q.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/req_encoder_4_2.md
# req_encoder_4_2

Registered 4-to-2 priority encoder with event capture and a valid/ack handshake: the encoding counterpart of the 2-to-4 enable decoder. Rising edges on four request lines are latched as pending events. The highest-priority pending event is presented as a 2-bit code that the decoder maps back to the same line. The block sits between raw request sources (buttons, peripheral strobes) and the consumer that drives the decoder.

## Interface
Parameters: none; width fixed at 4 lines / 2-bit code.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  4  request lines, already synchronous to clk; an event is a 0→1 transition
- en  in  1  capture/issue enable
- ack  in  1  consumer accepts the presented code; sampled only while valid=1
- code  out  2  encoded line; line i ↔ code 3−i (req[3]→00, req[2]→01, req[1]→10, req[0]→11)
- valid  out  1  code is meaningful and held until ack
- pending  out  4  latched, not-yet-acknowledged events, bit i = line i
- ovf  out  1  sticky overrun flag

## Operation
- Edge detect: req_q registers req each cycle; edge = req & ~req_q.
- Capture: when en=1, pending |= edge. When en=0, edges are discarded; existing pending bits are kept.
- Priority: req[3] highest, req[0] lowest, so the lowest code wins.
- Overrun: ovf sets when en=1 and an edge arrives on a line whose pending bit is already 1 and is not being cleared that cycle. The event is merged, not queued. ovf clears only on reset.
- FSM, 2 states:
  - IDLE (valid=0): if en=1 and pending≠0, load code = 3−(index of highest set pending bit), go PRESENT. Otherwise stay.
  - PRESENT (valid=1): code and valid are held stable. On ack=1, clear pending[3−code], go IDLE. en has no effect in PRESENT.
- Simultaneous clear and new edge on the same line: set wins. The bit stays 1 and ovf is not set.
- ack while in IDLE is ignored.
- Reset (at any time, including mid-handshake): state=IDLE, code=00, valid=0, pending=0000, ovf=0, req_q=0000. A line held high across reset is therefore seen as one event in the first cycle after reset.

## Timing
- Request to valid: req first sampled high at edge E0 sets pending after E0. The code loads and valid=1 after E1, so latency is 2 cycles.
- Ack to release: ack sampled high at edge Ek (valid=1) gives valid=0 and the pending bit cleared after Ek.
- Next issue: the earliest next valid is after Ek+1. Maximum throughput is one code per 2 cycles.
- Between grants: code holds its last value while valid=0; the consumer must ignore it.
- pending and ovf update every cycle independently of the FSM state.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then single event: reset high 2 cycles, hold req=0000; pulse req[1] 1 cycle. Expect pending=0010 after 1 cycle and code=10, valid=1 after 2. Hold ack=0 for 5 cycles: code/valid stable. ack=1 for 1 cycle: valid=0, pending=0000 next cycle.
- Priority order: raise req=0101 in one cycle. Expect code=01 (line 2) first. After ack, IDLE 1 cycle, then code=11 (line 0). After second ack, pending=0000.
- Enable gating: en=0, pulse req[3]. Expect pending stays 0000 and valid stays 0. Set pending=1000 with en=1, then drop en=0: no issue. Raise en: code=00, valid=1 after 1 cycle.
- Overrun vs set-wins: line 2 pending and presented; re-pulse req[2] without ack → ovf=1. Reset. Repeat with the re-pulse edge in the same cycle as ack → pending[2] stays 1, ovf=0, code=01 issued again.
- Reset mid-handshake: valid=1, code=10, pending=1010. Assert reset 1 cycle with req=0001 held. Expect all outputs 0 after reset. With req[0] still high, pending=0001 one cycle after reset release and code=11, valid=1 one cycle later.
